from_fx3_reader: RTL and testbench

- Receive-side counterpart of the FPGA-to-FX3 writer: reads host-to-device data from the Cypress FX3 GPIF II synchronous slave FIFO.
- Drives slcs/sloe/slrd/faddr on the read socket and captures fdata with the fixed FX3 read latency.
- Buffers captured words in a small skid FIFO and presents them as a valid/ready stream to FPGA command/config logic in the same 100 MHz clk domain.
- Shares the fdata bus with the writer; an external arbiter grants it through rd_grant_i.

---
 rtl/fx3_gpif_pkg.sv | 20 ++
 rtl/fx3_rd_skid_fifo.sv | 49 ++++
 rtl/from_fx3_reader.sv | 147 ++++++++++++++
 tb/tb_from_fx3_reader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx3_gpif_pkg.sv
// FX3 GPIF II slave-FIFO definitions shared by the reader and the writer.
package fx3_gpif_pkg;

  localparam logic SIGNAL_ACTIVE     = 1'b0;
  localparam logic SIGNAL_NOT_ACTIVE = 1'b1;

  localparam logic [1:0] WR_SOCK_ADDR = 2'b00;
  localparam logic [1:0] RD_SOCK_ADDR = 2'b11;

  localparam int RD_LAT_DEF = 2;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_SELECT,
    RD_READ,
    RD_STOP,
    RD_DRAIN
  } rd_state_t;

endpackage

// File: rtl/fx3_rd_skid_fifo.sv
// First-word-fall-through skid buffer for words captured from the FX3.
module fx3_rd_skid_fifo #(
  parameter int  DATA_W = 32,
  parameter int  DEPTH  = 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       free_slots
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign do_pop     = pop & ~empty;
  assign do_push    = push & (~full | do_pop);
  assign full       = count == (AW+1)'(DEPTH);
  assign empty      = count == '0;
  assign free_slots = (AW+1)'(DEPTH) - count;
  assign pop_data   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/from_fx3_reader.sv
// Host-to-device reader for the FX3 slave FIFO read socket.
module from_fx3_reader
  import fx3_gpif_pkg::*;
#(
  parameter int         DATA_W     = 32,
  parameter int         RD_LAT     = RD_LAT_DEF,
  parameter int         SKID_DEPTH = 8,
  parameter logic [1:0] RD_ADDR    = RD_SOCK_ADDR,
  parameter bit         WM_STOP    = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable_i,
  input  logic              rd_grant_i,
  output logic              rd_req_o,
  input  logic [DATA_W-1:0] fdata_i,
  input  logic              flagc,
  input  logic              flagd,
  output logic [1:0]        faddr,
  output logic              slcs,
  output logic              sloe,
  output logic              slrd,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [31:0]       words_rcvd_o,
  output logic              ovf_err_o
);

  localparam int AW = $clog2(SKID_DEPTH);
  localparam int CW = AW + 2;
  localparam logic signed [CW-1:0] LAT_S = CW'(RD_LAT);

  rd_state_t                state;
  logic [DATA_W-1:0]        fdata_q;
  logic [RD_LAT-2:0]        infl_sr;
  logic [RD_LAT-1:0]        inflight;
  logic                     capture;
  logic                     pop;
  logic                     push_ok;
  logic                     full;
  logic                     empty;
  logic [AW:0]              free_slots;
  logic signed [CW-1:0]     credit;
  logic                     credit_ok;
  logic                     can_read;
  logic [31:0]              rcvd_cnt;
  logic                     ovf_q;

  // bit0 is the strobe on the pins right now; older strobes shift up
  assign inflight  = {infl_sr, ~slrd};
  assign capture   = inflight[RD_LAT-1];
  assign pop       = m_valid_o & m_ready_i;
  assign push_ok   = capture & (~full | pop);

  assign credit    = signed'(CW'(free_slots))
                   - signed'(CW'($countones(inflight)));
  assign credit_ok = credit > LAT_S;
  assign can_read  = flagc & (flagd | ~WM_STOP)
                   & credit_ok & enable_i & rd_grant_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fdata_q  <= '0;
      infl_sr  <= '0;
      rcvd_cnt <= '0;
      ovf_q    <= 1'b0;
    end else begin
      fdata_q <= fdata_i;
      infl_sr <= inflight[RD_LAT-2:0];
      if (push_ok)                rcvd_cnt <= rcvd_cnt + 32'd1;
      if (capture & full & ~pop) ovf_q    <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= RD_IDLE;
      slcs     <= SIGNAL_NOT_ACTIVE;
      sloe     <= SIGNAL_NOT_ACTIVE;
      slrd     <= SIGNAL_NOT_ACTIVE;
      faddr    <= RD_ADDR;
      rd_req_o <= 1'b0;
    end else begin
      faddr    <= RD_ADDR;
      rd_req_o <= flagc & enable_i;
      unique case (state)
        RD_IDLE: begin
          // SELECT always issues one strobe, so room must exist first
          if (flagc & enable_i & rd_grant_i & credit_ok) begin
            state <= RD_SELECT;
            slcs  <= SIGNAL_ACTIVE;
            sloe  <= SIGNAL_ACTIVE;
          end
        end
        RD_SELECT: begin
          state <= RD_READ;
          slrd  <= SIGNAL_ACTIVE;
        end
        RD_READ: begin
          if (!can_read) begin
            state <= RD_STOP;
            slrd  <= SIGNAL_NOT_ACTIVE;
          end
        end
        RD_STOP: begin
          state <= RD_DRAIN;
        end
        RD_DRAIN: begin
          if (inflight == '0) begin
            if (can_read) begin
              state <= RD_READ;
              slrd  <= SIGNAL_ACTIVE;
            end else begin
              state <= RD_IDLE;
              slcs  <= SIGNAL_NOT_ACTIVE;
              sloe  <= SIGNAL_NOT_ACTIVE;
            end
          end
        end
        default: begin
          state <= RD_IDLE;
        end
      endcase
    end
  end

  fx3_rd_skid_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (SKID_DEPTH)
  ) u_skid (
    .clk        (clk),
    .rstn       (rstn),
    .push       (push_ok),
    .push_data  (fdata_q),
    .pop        (pop),
    .pop_data   (m_data_o),
    .full       (full),
    .empty      (empty),
    .free_slots (free_slots)
  );

  assign m_valid_o    = ~empty;
  assign words_rcvd_o = rcvd_cnt;
  assign ovf_err_o    = ovf_q;

endmodule

// File: tb/tb_from_fx3_reader.sv
// Random-data bench: FX3 socket model feeding a scoreboard of expected stream words.
module tb_from_fx3_reader;
  import fx3_gpif_pkg::*;

  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              enable_i = 1'b0;
  logic              rd_grant_i = 1'b0;
  logic              flagc = 1'b0;
  logic              flagd = 1'b0;
  logic              m_ready_i = 1'b0;
  logic [DATA_W-1:0] fdata_i = '0;
  logic              rd_req_o;
  logic [1:0]        faddr;
  logic              slcs;
  logic              sloe;
  logic              slrd;
  logic [DATA_W-1:0] m_data_o;
  logic              m_valid_o;
  logic [31:0]       words_rcvd_o;
  logic              ovf_err_o;

  always #5 clk = ~clk;

  from_fx3_reader dut (
    .clk          (clk),
    .rstn         (rstn),
    .enable_i     (enable_i),
    .rd_grant_i   (rd_grant_i),
    .rd_req_o     (rd_req_o),
    .fdata_i      (fdata_i),
    .flagc        (flagc),
    .flagd        (flagd),
    .faddr        (faddr),
    .slcs         (slcs),
    .sloe         (sloe),
    .slrd         (slrd),
    .m_data_o     (m_data_o),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .words_rcvd_o (words_rcvd_o),
    .ovf_err_o    (ovf_err_o)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] fx_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_word;
  logic [31:0] exp_rcvd = '0;
  int          avail_prev = 0;
  logic        fx_rd;
  int          cyc = 0;
  int          strobes = 0;
  int          runs = 0;
  logic        slrd_d = 1'b1;
  int          first_pop = -1;
  int          last_pop = -1;
  int          first_valid = -1;
  int          first_strobe = -1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // FX3 socket: flags lag the word count by one cycle
  always begin
    @(negedge clk);
    fx_rd = rstn && !slcs && !sloe && !slrd && faddr == RD_SOCK_ADDR;
    @(posedge clk);
    #1;
    if (fx_rd) begin
      n_chk++;
      if (fx_q.size() == 0) begin
        n_fail++;
        $display("FAIL fx3_underrun: strobe with 0 words, required >0");
      end else begin
        exp_q.push_back(fx_q.pop_front());
      end
    end
    flagc      = avail_prev > 0;
    flagd      = avail_prev > RD_LAT;
    avail_prev = fx_q.size();
    fdata_i    = (fx_q.size() != 0) ? fx_q[0] : $urandom;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rstn && !slrd && !slcs) begin
      strobes++;
      if (slrd_d) runs++;
      if (first_strobe < 0) first_strobe = cyc;
    end
    slrd_d = slrd;
    if (rstn && m_valid_o && first_valid < 0) first_valid = cyc;
    if (rstn && m_valid_o && m_ready_i) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL stream_extra: got %h, required no word", m_data_o);
      end else begin
        exp_word = exp_q.pop_front();
        if (m_data_o !== exp_word) begin
          n_fail++;
          $display("FAIL stream_data: got %h, required %h", m_data_o, exp_word);
        end
      end
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mark();
    strobes      = 0;
    runs         = 0;
    first_pop    = -1;
    last_pop     = -1;
    first_valid  = -1;
    first_strobe = -1;
  endtask

  task automatic load(input int n, input bit ramp);
    for (int i = 0; i < n; i++)
      fx_q.push_back(ramp ? 32'(i) : $urandom);
    exp_rcvd += 32'(n);
  endtask

  task automatic wait_done(input string name, input int budget, input bit rnd);
    int t = 0;
    while ((fx_q.size() != 0 || exp_q.size() != 0 || slcs !== 1'b1)
           && t < budget) begin
      if (rnd) m_ready_i = $urandom_range(0, 3) != 0;
      tick();
      t++;
    end
    m_ready_i = 1'b1;
    tick(3);
    n_chk++;
    if (t >= budget) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d words pending, required 0",
               name, fx_q.size() + exp_q.size());
    end
  endtask

  task automatic wait_strobes(input string name, input int n);
    int t = 0;
    while (strobes < n && t < 300) begin
      tick();
      t++;
    end
    check({name, "_reached"}, strobes >= n, 1'b1);
  endtask

  task automatic check_reset(input string name);
    check({name, "_slcs"}, slcs, 1'b1);
    check({name, "_sloe"}, sloe, 1'b1);
    check({name, "_slrd"}, slrd, 1'b1);
    check({name, "_faddr"}, faddr, RD_SOCK_ADDR);
    check({name, "_rd_req"}, rd_req_o, 1'b0);
    check({name, "_valid"}, m_valid_o, 1'b0);
    check({name, "_data"}, m_data_o, '0);
    check({name, "_count"}, words_rcvd_o, '0);
    check({name, "_ovf"}, ovf_err_o, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    logic [31:0] wrap_exp;
    tick(3);
    @(negedge clk);
    check_reset("reset");
    tick();
    rstn = 1'b1;
    enable_i = 1'b1;
    rd_grant_i = 1'b1;
    m_ready_i = 1'b1;
    tick(2);

    mark();
    load(64, 1'b1);
    wait_done("basic", 400, 1'b0);
    check("basic_strobes", strobes, 64);
    check("basic_runs", runs, 1);
    check("basic_gapless", last_pop - first_pop, 63);
    check("basic_latency", first_valid - first_strobe, RD_LAT);
    check("basic_count", words_rcvd_o, exp_rcvd);

    mark();
    m_ready_i = 1'b0;
    load(100, 1'b0);
    tick(40);
    check("bp_slrd_high", slrd, 1'b1);
    check("bp_valid", m_valid_o, 1'b1);
    check("bp_buffered_le_depth", exp_q.size() <= DEPTH, 1'b1);
    check("bp_ovf", ovf_err_o, 1'b0);
    wait_done("bp", 4000, 1'b1);
    check("bp_count", words_rcvd_o, exp_rcvd);
    check("bp_ovf_end", ovf_err_o, 1'b0);

    mark();
    load(32, 1'b0);
    wait_done("wm", 400, 1'b0);
    check("wm_strobes", strobes, 32);
    check("wm_runs", runs, 1);
    check("wm_slcs", slcs, 1'b1);
    check("wm_count", words_rcvd_o, exp_rcvd);

    mark();
    load(50, 1'b0);
    wait_strobes("grant", 15);
    rd_grant_i = 1'b0;
    tick();
    check("grant_slrd_next", slrd, 1'b1);
    s0 = strobes;
    tick(6);
    check("grant_no_strobe", strobes, s0);
    check("grant_released", slcs, 1'b1);
    check("grant_inflight_out", exp_q.size(), 0);
    check("grant_req", rd_req_o, 1'b1);
    rd_grant_i = 1'b1;
    wait_done("grant", 600, 1'b0);
    check("grant_count", words_rcvd_o, exp_rcvd);

    mark();
    load(40, 1'b0);
    wait_strobes("rst", 10);
    rstn = 1'b0;
    #1;
    check_reset("midrst");
    fx_q.delete();
    exp_q.delete();
    exp_rcvd = '0;
    tick(3);
    rstn = 1'b1;
    load(20, 1'b0);
    wait_done("rst", 400, 1'b0);
    check("rst_count", words_rcvd_o, exp_rcvd);

    force dut.rcvd_cnt = 32'hFFFF_FFFE;
    tick();
    release dut.rcvd_cnt;
    tick();
    wrap_exp = 32'hFFFF_FFFE;
    wrap_exp += 32'd3;
    load(3, 1'b0);
    wait_done("wrap", 200, 1'b0);
    check("wrap_count", words_rcvd_o, wrap_exp);
    check("final_ovf", ovf_err_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
